// File: rtl/loong_add_const.sv
// Round-constant XOR stage: latches a state/round pair, fetches the round constant, and emits state ^ constant.
// Optional macro LOONG_RC_TIMEOUT_EN adds a WAIT_RC timeout that pulses err and drops the transaction.
module loong_add_const #(
  parameter int NUM_ROUNDS = 33
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_state,
  input  logic [5:0]            in_round,
  output logic [5:0]            j,
  input  logic                  rc_valid,
  input  logic [0:3][0:3][3:0]  rc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_state,
  output logic                  busy,
  output logic                  err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] WAIT_RC = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  localparam logic [6:0] NR = 7'(NUM_ROUNDS);

  logic [1:0]  fsm_q, fsm_d;
  logic [63:0] state_q, state_d;
  logic [5:0]  j_q, j_d;
  logic [63:0] out_state_q, out_state_d;

`ifdef LOONG_RC_TIMEOUT_EN
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    j_d         = j_q;
    out_state_d = out_state_q;
`ifdef LOONG_RC_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_state;
          if ({1'b0, in_round} < NR) begin
            j_d   = in_round;
            fsm_d = SETTLE;
          end else begin
            out_state_d = in_state;
            fsm_d       = OUT;
          end
        end
      end
      // rc_valid here still describes the previous j, so it is not looked at.
      SETTLE: begin
        fsm_d = WAIT_RC;
`ifdef LOONG_RC_TIMEOUT_EN
        cnt_d = 3'd0;
`endif
      end
      WAIT_RC: begin
        if (rc_valid) begin
          // rc_in[r][c] packs to the same bit positions as state nibble (r,c).
          out_state_d = state_q ^ rc_in;
          fsm_d       = OUT;
        end
`ifdef LOONG_RC_TIMEOUT_EN
        else if (cnt_q == 3'd7) begin
          err_d = 1'b1;
          fsm_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
`endif
      end
      OUT: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      fsm_q       <= IDLE;
      state_q     <= 64'd0;
      j_q         <= 6'd0;
      out_state_q <= 64'd0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      j_q         <= j_d;
      out_state_q <= out_state_d;
    end
  end

`ifdef LOONG_RC_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (fsm_q == IDLE) && !rst;
  assign out_valid = (fsm_q == OUT);
  assign busy      = (fsm_q != IDLE);
  assign j         = j_q;
  assign out_state = out_state_q;

endmodule

// File: tb/tb_loong_add_const.sv
// Randomized bench for loong_add_const with a toggling round-constant generator model.
module tb_loong_add_const;

  localparam int NR = 33;

  logic                 clock = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [63:0]          in_state = 64'd0;
  logic [5:0]           in_round = 6'd0;
  logic [5:0]           j;
  logic                 rc_valid = 1'b0;
  logic [0:3][0:3][3:0] rc_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [63:0]          out_state;
  logic                 busy;
  logic                 err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] rc_tbl [0:63];
  logic [5:0]  model_j;

  loong_add_const #(.NUM_ROUNDS(NR)) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_round(in_round),
    .j(j), .rc_valid(rc_valid), .rc_in(rc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Generator toggles its done flag; the genuine constant is only offered from cycle 2 on.
  task automatic drive_gen(input int c, input int phase, input bit stale, input logic [5:0] rnd);
    rc_valid = ((c + phase) % 2 == 0);
    if (stale && c == 1) rc_valid = 1'b1;
    if (rc_valid && c >= 2) rc_in = rc_tbl[rnd];
    else                    rc_in = {$urandom, $urandom};
  endtask

  task automatic run_txn(input logic [63:0] st, input logic [5:0] rnd, input int phase,
                         input bit stale, input int hold);
    bit          inr;
    logic [63:0] exp;
    logic [5:0]  exp_j;
    int          exp_lat;
    int          lat;
    inr     = (int'(rnd) < NR);
    exp     = inr ? (st ^ rc_tbl[rnd]) : st;
    exp_j   = inr ? rnd : model_j;
    exp_lat = !inr ? 1 : (phase == 0 ? 3 : 4);
    lat     = -1;
    check_eq("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_state  = st;
    in_round  = rnd;
    out_ready = 1'b0;
    drive_gen(0, phase, stale, rnd);
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      in_valid = 1'b0;
      in_state = {$urandom, $urandom};
      in_round = 6'($urandom_range(0, 63));
      if (c == 1) check_eq("j", j, exp_j);
      if (out_valid) lat = c;
      else drive_gen(c, phase, stale, rnd);
    end
    check_eq("latency", lat, exp_lat);
    if (lat > 0) begin
      check_eq("out_state", out_state, exp);
      check_eq("err_idle", err, 0);
      check_eq("busy_out", busy, 1);
      check_eq("in_ready_out", in_ready, 0);
      for (int h = 0; h < hold; h++) begin
        drive_gen(lat + h, phase, 1'b0, rnd);
        tick();
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_state", out_state, exp);
        check_eq("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq("in_ready_after", in_ready, 1);
      check_eq("out_valid_after", out_valid, 0);
      check_eq("busy_after", busy, 0);
    end
    if (inr) model_j = rnd;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rc_tbl[i] = {$urandom, $urandom};
    rc_tbl[0]  = 64'h0001_0010_0020_0040;
    rc_tbl[25] = 64'h0000_0001_0002_0005;
    model_j = 6'd0;

    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    tick();
    check_eq("rst_in_ready_after", in_ready, 1);
    check_eq("rst_out_state", out_state, 0);
    check_eq("rst_j", j, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);

    run_txn(64'h0, 6'd0, 0, 1'b0, 0);
    run_txn(64'hFFFF_FFFF_FFFF_FFFF, 6'd25, 1, 1'b0, 0);
    run_txn({$urandom, $urandom}, 6'd7, 0, 1'b1, 0);
    run_txn(64'h0123_4567_89AB_CDEF, 6'd40, 0, 1'b0, 0);
    run_txn({$urandom, $urandom}, 6'd12, 1, 1'b0, 10);
    run_txn({$urandom, $urandom}, 6'd32, 0, 1'b0, 1);
    run_txn({$urandom, $urandom}, 6'd33, 1, 1'b0, 0);

    // Reset while waiting for the constant abandons the transaction.
    in_valid = 1'b1;
    in_state = {$urandom, $urandom};
    in_round = 6'd5;
    rc_valid = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_j", j, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    model_j = 6'd0;
    for (int k = 0; k < 3; k++) begin
      rc_valid = 1'b1;
      rc_in = {$urandom, $urandom};
      tick();
      check_eq("post_rst_out_valid", out_valid, 0);
      check_eq("post_rst_busy", busy, 0);
    end
    rc_valid = 1'b0;

`ifdef LOONG_RC_TIMEOUT_EN
    begin
      int err_first;
      int err_cnt;
      int ov_cnt;
      err_first = -1;
      err_cnt   = 0;
      ov_cnt    = 0;
      in_valid = 1'b1;
      in_state = {$urandom, $urandom};
      in_round = 6'd3;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 14; c++) begin
        if (err) begin
          err_cnt++;
          if (err_first < 0) begin
            err_first = c;
            check_eq("timeout_in_ready", in_ready, 1);
          end
        end
        if (out_valid) ov_cnt++;
        if (c < 14) tick();
      end
      check_eq("timeout_err_cycle", err_first, 10);
      check_eq("timeout_err_count", err_cnt, 1);
      check_eq("timeout_no_out", ov_cnt, 0);
      model_j = 6'd3;
    end
`endif

    for (int t = 0; t < 25; t++) begin
      run_txn({$urandom, $urandom}, 6'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
